// File: rtl/voice_allocator.sv
// Voice allocator: assigns note-on/note-off events to a bank of oscillators.
// Each event is handled by a fixed-length state sequence, so every event takes the
// same number of cycles. A linear scan first finds a same-note voice, a free voice and
// the oldest voice. Note-on then uses a matching voice first, a free voice next, and
// steals the oldest voice last.
module voice_allocator #(
    parameter int unsigned N_VOICES   = 16,
    parameter int unsigned FREQ_WIDTH = 32,
    parameter int unsigned NOTE_WIDTH = 7,
    parameter int unsigned AGE_WIDTH  = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 ev_valid,
    output logic                                 ev_ready,
    input  logic                                 ev_on,
    input  logic [NOTE_WIDTH-1:0]                ev_note,
    input  logic [FREQ_WIDTH-1:0]                ev_freq,
    output logic [N_VOICES-1:0][7:0]             voice_cmds,
    output logic [N_VOICES-1:0][FREQ_WIDTH-1:0]  voice_freq,
    output logic signed [31:0]                   num_enabled,
    output logic                                 stolen
);

    localparam int unsigned IdxW = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;
    localparam int unsigned CntW = $clog2(N_VOICES + 3);

    typedef enum logic [2:0] {StIdle, StScan, StTrig, StArm, StRel, StWait} state_e;

    state_e                             state_q, state_d;
    logic [CntW-1:0]                    cyc_q, cyc_d;
    logic                               ev_on_q, ev_on_d;
    logic [NOTE_WIDTH-1:0]              ev_note_q, ev_note_d;
    logic [FREQ_WIDTH-1:0]              ev_freq_q, ev_freq_d;
    logic                               match_found_q, match_found_d;
    logic [IdxW-1:0]                    match_idx_q, match_idx_d;
    logic                               free_found_q, free_found_d;
    logic [IdxW-1:0]                    free_idx_q, free_idx_d;
    logic [IdxW-1:0]                    old_idx_q, old_idx_d;
    logic [AGE_WIDTH-1:0]               old_age_q, old_age_d;
    logic [N_VOICES-1:0]                rel_mask_q, rel_mask_d;
    logic [IdxW-1:0]                    tgt_q, tgt_d;
    logic [N_VOICES-1:0][7:0]           cmds_q, cmds_d;
    logic [N_VOICES-1:0][FREQ_WIDTH-1:0] freq_q, freq_d;
    logic [N_VOICES-1:0][NOTE_WIDTH-1:0] note_q, note_d;
    logic [N_VOICES-1:0][AGE_WIDTH-1:0] age_q, age_d;
    logic [31:0]                        num_q, num_d;
    logic                               stolen_q, stolen_d;
    logic                               ev_ready_q, ev_ready_d;

    logic [IdxW-1:0]                    scan_idx;
    logic                               scan_en, scan_hit;
    logic [IdxW-1:0]                    tgt;

    // Popcount of ENABLE bits of the current registered cmds; registered next edge.
    always_comb begin
        num_d = '0;
        for (int i = 0; i < N_VOICES; i++) begin
            num_d = num_d + 32'(cmds_q[i][1]);
        end
    end

    // Next-state logic for the event sequencer and all voice state.
    always_comb begin
        state_d       = state_q;
        cyc_d         = cyc_q;
        ev_on_d       = ev_on_q;
        ev_note_d     = ev_note_q;
        ev_freq_d     = ev_freq_q;
        match_found_d = match_found_q;
        match_idx_d   = match_idx_q;
        free_found_d  = free_found_q;
        free_idx_d    = free_idx_q;
        old_idx_d     = old_idx_q;
        old_age_d     = old_age_q;
        rel_mask_d    = rel_mask_q;
        tgt_d         = tgt_q;
        cmds_d        = cmds_q;
        freq_d        = freq_q;
        note_d        = note_q;
        age_d         = age_q;
        stolen_d      = 1'b0;
        ev_ready_d    = ev_ready_q;
        scan_idx      = cyc_q[IdxW-1:0];
        scan_en       = cmds_q[scan_idx][1];
        scan_hit      = scan_en && (note_q[scan_idx] == ev_note_q);
        tgt           = match_found_q ? match_idx_q : (free_found_q ? free_idx_q : old_idx_q);

        unique case (state_q)
            StIdle: begin
                if (ev_valid && ev_ready_q) begin
                    ev_on_d       = ev_on;
                    ev_note_d     = ev_note;
                    ev_freq_d     = ev_freq;
                    cyc_d         = '0;
                    match_found_d = 1'b0;
                    free_found_d  = 1'b0;
                    old_idx_d     = '0;
                    old_age_d     = '0;
                    rel_mask_d    = '0;
                    ev_ready_d    = 1'b0;
                    state_d       = StScan;
                end
            end
            StScan: begin
                cyc_d = cyc_q + CntW'(1);
                if (scan_hit && !match_found_q) begin
                    match_found_d = 1'b1;
                    match_idx_d   = scan_idx;
                end
                if (!scan_en && !free_found_q) begin
                    free_found_d = 1'b1;
                    free_idx_d   = scan_idx;
                end
                // Strict '>' keeps the lowest index on equal ages.
                if (cyc_q == '0 || age_q[scan_idx] > old_age_q) begin
                    old_idx_d = scan_idx;
                    old_age_d = age_q[scan_idx];
                end
                rel_mask_d[scan_idx] = scan_hit;
                if (cyc_q == CntW'(N_VOICES - 1)) begin
                    state_d = ev_on_q ? StTrig : StRel;
                end
            end
            StTrig: begin
                cyc_d    = cyc_q + CntW'(1);
                tgt_d    = tgt;
                stolen_d = !match_found_q && !free_found_q;
                for (int i = 0; i < N_VOICES; i++) begin
                    if (IdxW'(i) == tgt) begin
                        cmds_d[i] = 8'b11;
                        freq_d[i] = ev_freq_q;
                        note_d[i] = ev_note_q;
                        age_d[i]  = '0;
                    end else if (cmds_q[i][1] && age_q[i] != '1) begin
                        age_d[i] = age_q[i] + AGE_WIDTH'(1);
                    end
                end
                state_d = StArm;
            end
            StArm: begin
                cyc_d          = cyc_q + CntW'(1);
                cmds_d[tgt_q]  = 8'b10;
                state_d        = StWait;
            end
            StRel: begin
                cyc_d = cyc_q + CntW'(1);
                for (int i = 0; i < N_VOICES; i++) begin
                    if (rel_mask_q[i]) begin
                        cmds_d[i] = 8'b0;
                    end
                end
                state_d = StWait;
            end
            StWait: begin
                // Pads both paths so the next event is accepted at a fixed latency.
                cyc_d = cyc_q + CntW'(1);
                if (cyc_q == CntW'(N_VOICES + 2)) begin
                    ev_ready_d = 1'b1;
                    state_d    = StIdle;
                end
            end
            default: begin
                ev_ready_d = 1'b1;
                state_d    = StIdle;
            end
        endcase
    end

    // State register with synchronous reset; reset discards any event in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            cyc_q         <= '0;
            ev_on_q       <= 1'b0;
            ev_note_q     <= '0;
            ev_freq_q     <= '0;
            match_found_q <= 1'b0;
            match_idx_q   <= '0;
            free_found_q  <= 1'b0;
            free_idx_q    <= '0;
            old_idx_q     <= '0;
            old_age_q     <= '0;
            rel_mask_q    <= '0;
            tgt_q         <= '0;
            cmds_q        <= '0;
            freq_q        <= '0;
            note_q        <= '0;
            age_q         <= '0;
            num_q         <= '0;
            stolen_q      <= 1'b0;
            ev_ready_q    <= 1'b1;
        end else begin
            state_q       <= state_d;
            cyc_q         <= cyc_d;
            ev_on_q       <= ev_on_d;
            ev_note_q     <= ev_note_d;
            ev_freq_q     <= ev_freq_d;
            match_found_q <= match_found_d;
            match_idx_q   <= match_idx_d;
            free_found_q  <= free_found_d;
            free_idx_q    <= free_idx_d;
            old_idx_q     <= old_idx_d;
            old_age_q     <= old_age_d;
            rel_mask_q    <= rel_mask_d;
            tgt_q         <= tgt_d;
            cmds_q        <= cmds_d;
            freq_q        <= freq_d;
            note_q        <= note_d;
            age_q         <= age_d;
            num_q         <= num_d;
            stolen_q      <= stolen_d;
            ev_ready_q    <= ev_ready_d;
        end
    end

    assign ev_ready    = ev_ready_q;
    assign voice_cmds  = cmds_q;
    assign voice_freq  = freq_q;
    assign num_enabled = signed'(num_q);
    assign stolen      = stolen_q;

endmodule
